// File: rtl/branch_predict_unit_pkg.sv
// branch_predict_unit_pkg: shared types, reset constant and PC slicing helpers
// for the gshare/BTB/RAS branch predictor.
package branch_predict_unit_pkg;

    typedef enum logic [1:0] {
        BRANCH = 2'd0,
        JUMP   = 2'd1,
        RET    = 2'd2
    } btb_type_e;

    localparam logic [1:0] WEAK_NT = 2'b01;

    function automatic logic [63:0] pc_field(input logic [63:0] pc, input int unsigned lsb,
                                             input int unsigned width);
        return (pc >> lsb) & ((64'd1 << width) - 64'd1);
    endfunction

    // BTB tag sits directly above the word-aligned index bits
    function automatic int unsigned tag_lsb(input int unsigned entries);
        return 32'($clog2(entries)) + 32'd2;
    endfunction

endpackage

// File: rtl/ras_stack.sv
// ras_stack: circular return-address stack; pop is applied before push so a
// combined call+ret replaces the top entry in place.
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic [XLEN-1:0]              push_data_i,
    output logic [XLEN-1:0]              top_o,
    output logic [$clog2(RAS_DEPTH):0]   count_o
);
    localparam int RW = $clog2(RAS_DEPTH);
    localparam int CW = RW + 1;

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [RW-1:0]   ptr_q, ptr_d, ptr_pop;
    logic [CW-1:0]   cnt_q, cnt_d, cnt_pop;
    logic            do_pop;

    assign do_pop  = pop_i && cnt_q != '0;
    assign ptr_pop = do_pop ? ptr_q - RW'(1) : ptr_q;
    assign cnt_pop = do_pop ? cnt_q - CW'(1) : cnt_q;
    assign ptr_d   = push_i ? ptr_pop + RW'(1) : ptr_pop;
    // a push when full wraps onto the oldest entry and keeps the count saturated
    assign cnt_d   = (push_i && cnt_pop != CW'(RAS_DEPTH)) ? cnt_pop + CW'(1) : cnt_pop;
    assign top_o   = mem_q[ptr_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[ptr_d] <= push_data_i;
    end

endmodule

// File: rtl/branch_predict_unit.sv
// branch_predict_unit: gshare direction predictor with tagged direct-mapped BTB
// and return-address stack; combinational lookup in IF, trained from ID.
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int GHR_BITS    = 5,
    parameter int BTB_ENTRIES = 32,
    parameter int TAG_BITS    = 8,
    parameter int RAS_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                is_stall,
    input  logic [XLEN-1:0]     IF_pc,
    output logic [XLEN-1:0]     predicted_pc,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [XLEN-1:0]     upd_pc,
    input  logic [GHR_BITS-1:0] upd_ghr,
    input  logic                upd_is_branch,
    input  logic                upd_is_jump,
    input  logic                upd_is_call,
    input  logic                upd_is_ret,
    input  logic                upd_taken,
    input  logic [XLEN-1:0]     upd_target
);
    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int RW = $clog2(RAS_DEPTH);

    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [1:0]          pht_q [2**GHR_BITS];
    logic                btb_valid_q [BTB_ENTRIES];
    logic [TAG_BITS-1:0] btb_tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]     btb_tgt_q [BTB_ENTRIES];
    btb_type_e           btb_type_q [BTB_ENTRIES];

    logic [XLEN-1:0]     pc_plus4, tgt, ras_top;
    logic [RW:0]         ras_count;
    logic [GHR_BITS-1:0] pht_idx, upd_pht_idx;
    logic [IW-1:0]       btb_idx, upd_btb_idx;
    logic [TAG_BITS-1:0] btb_tag, upd_tag;
    logic [1:0]          ctr, ctr_d;
    logic                hit, upd_en, upd_btb;
    btb_type_e           hit_type, upd_type;

    assign btb_idx     = IW'(pc_field(64'(IF_pc), 2, IW));
    assign btb_tag     = TAG_BITS'(pc_field(64'(IF_pc), tag_lsb(BTB_ENTRIES), TAG_BITS));
    assign pht_idx     = GHR_BITS'(pc_field(64'(IF_pc), 2, GHR_BITS)) ^ ghr_q;
    assign upd_btb_idx = IW'(pc_field(64'(upd_pc), 2, IW));
    assign upd_tag     = TAG_BITS'(pc_field(64'(upd_pc), tag_lsb(BTB_ENTRIES), TAG_BITS));
    // training uses the history snapshot that made the prediction, not the live GHR
    assign upd_pht_idx = GHR_BITS'(pc_field(64'(upd_pc), 2, GHR_BITS)) ^ upd_ghr;

    assign pc_plus4 = IF_pc + XLEN'(4);
    assign hit      = btb_valid_q[btb_idx] && btb_tag_q[btb_idx] == btb_tag;
    assign hit_type = btb_type_q[btb_idx];
    assign tgt      = btb_tgt_q[btb_idx];

    assign predicted_pc = !hit ? pc_plus4 :
                          hit_type == RET ? (ras_count != '0 ? ras_top : tgt) :
                          (hit_type == JUMP || pht_q[pht_idx][1]) ? tgt : pc_plus4;
    assign pred_taken   = predicted_pc != pc_plus4;
    assign pred_ghr     = ghr_q;

    assign upd_en   = upd_valid && !is_stall;
    assign upd_btb  = upd_en && (upd_is_branch || upd_is_jump || upd_is_call || upd_is_ret);
    assign upd_type = upd_is_ret ? RET : (upd_is_jump || upd_is_call) ? JUMP : BRANCH;
    assign ctr      = pht_q[upd_pht_idx];
    assign ctr_d    = upd_taken ? (ctr == 2'b11 ? 2'b11 : ctr + 2'd1)
                                : (ctr == 2'b00 ? 2'b00 : ctr - 2'd1);
    assign ghr_d    = (upd_en && upd_is_branch) ? {ghr_q[GHR_BITS-2:0], upd_taken} : ghr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
            for (int i = 0; i < 2**GHR_BITS; i++) pht_q[i] <= WEAK_NT;
            for (int i = 0; i < BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
        end else begin
            ghr_q <= ghr_d;
            if (upd_en && upd_is_branch) pht_q[upd_pht_idx] <= ctr_d;
            if (upd_btb) btb_valid_q[upd_btb_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (upd_btb) begin
            btb_tag_q[upd_btb_idx]  <= upd_tag;
            btb_tgt_q[upd_btb_idx]  <= upd_target;
            btb_type_q[upd_btb_idx] <= upd_type;
        end
    end

    ras_stack #(
        .XLEN(XLEN),
        .RAS_DEPTH(RAS_DEPTH)
    ) u_ras (
        .clk(clk),
        .reset(reset),
        .push_i(upd_en && upd_is_call),
        .pop_i(upd_en && upd_is_ret),
        .push_data_i(upd_pc + XLEN'(4)),
        .top_o(ras_top),
        .count_o(ras_count)
    );

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit: directed and randomized checks of the predictor
// against a queue/array reference model built from the prediction rules.
module tb_branch_predict_unit;
    localparam logic [3:0] F_BR = 4'b1000, F_JMP = 4'b0100, F_CALL = 4'b0010, F_RET = 4'b0001;

    logic        clk = 1'b0;
    logic        reset, is_stall, upd_valid, upd_is_branch, upd_is_jump, upd_is_call, upd_is_ret, upd_taken;
    logic [31:0] IF_pc, predicted_pc, upd_pc, upd_target;
    logic [4:0]  pred_ghr, upd_ghr;
    logic        pred_taken;

    int total = 0, bad = 0;

    int unsigned m_pht [32];
    logic [4:0]  m_ghr;
    bit          m_valid [32];
    logic [7:0]  m_tag [32];
    logic [31:0] m_tgt [32];
    int          m_type [32];
    logic [31:0] m_ras [$];

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk(clk), .reset(reset), .is_stall(is_stall), .IF_pc(IF_pc),
        .predicted_pc(predicted_pc), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump),
        .upd_is_call(upd_is_call), .upd_is_ret(upd_is_ret),
        .upd_taken(upd_taken), .upd_target(upd_target)
    );

    function automatic logic [31:0] exp_pc(input logic [31:0] pc);
        int unsigned bi = (pc >> 2) % 32;
        int unsigned pi = ((pc >> 2) % 32) ^ 32'(m_ghr);
        if (!m_valid[bi] || m_tag[bi] != 8'((pc >> 7) % 256)) return pc + 4;
        if (m_type[bi] == 2) return m_ras.size() > 0 ? m_ras[$] : m_tgt[bi];
        if (m_type[bi] == 1 || m_pht[pi] >= 2) return m_tgt[bi];
        return pc + 4;
    endfunction

    task automatic clear_model();
        m_ghr = '0;
        foreach (m_pht[i]) m_pht[i] = 1;
        foreach (m_valid[i]) m_valid[i] = 0;
        m_ras.delete();
    endtask

    task automatic model_apply();
        int unsigned pi = ((upd_pc >> 2) % 32) ^ 32'(upd_ghr);
        int unsigned bi = (upd_pc >> 2) % 32;
        if (upd_is_branch) begin
            if (upd_taken) m_pht[pi] = m_pht[pi] == 3 ? 3 : m_pht[pi] + 1;
            else m_pht[pi] = m_pht[pi] == 0 ? 0 : m_pht[pi] - 1;
            m_ghr = {m_ghr[3:0], upd_taken};
        end
        if (upd_is_branch || upd_is_jump || upd_is_call || upd_is_ret) begin
            m_valid[bi] = 1;
            m_tag[bi]   = 8'((upd_pc >> 7) % 256);
            m_tgt[bi]   = upd_target;
            m_type[bi]  = upd_is_ret ? 2 : (upd_is_jump || upd_is_call) ? 1 : 0;
        end
        if (upd_is_ret && m_ras.size() > 0) void'(m_ras.pop_back());
        if (upd_is_call) begin
            m_ras.push_back(upd_pc + 4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        clear_model();
    endtask

    task automatic train(input logic [31:0] pc, input logic [4:0] g, input logic [3:0] f,
                         input logic tk, input logic [31:0] tgt, input logic stall);
        upd_valid = 1'b1; upd_pc = pc; upd_ghr = g; upd_taken = tk; upd_target = tgt; is_stall = stall;
        {upd_is_branch, upd_is_jump, upd_is_call, upd_is_ret} = f;
        @(posedge clk);
        #1;
        if (!stall) model_apply();
        upd_valid = 1'b0;
        is_stall = 1'b0;
    endtask

    task automatic test_reset();
        IF_pc = 32'h40;
        #1;
        total++; if (predicted_pc !== 32'h44) begin bad++; $display("FAIL reset_pc got=%h exp=%h", predicted_pc, 32'h44); end
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", pred_taken); end
        total++; if (pred_ghr !== 5'd0) begin bad++; $display("FAIL reset_ghr got=%b exp=00000", pred_ghr); end
    endtask

    task automatic test_jump();
        train(32'h20, 5'd0, F_JMP, 1'b0, 32'h100, 1'b0);
        IF_pc = 32'h20;
        #1;
        total++; if (predicted_pc !== 32'h100) begin bad++; $display("FAIL jump_hit got=%h exp=%h", predicted_pc, 32'h100); end
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL jump_taken got=%b exp=1", pred_taken); end
        IF_pc = 32'hA0;
        #1;
        total++; if (predicted_pc !== 32'hA4) begin bad++; $display("FAIL jump_tag_miss got=%h exp=%h", predicted_pc, 32'hA4); end
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL jump_tag_miss_taken got=%b exp=0", pred_taken); end
    endtask

    task automatic test_gshare();
        do_reset();
        train(32'h10, 5'd0, F_BR, 1'b1, 32'h0, 1'b0);
        train(32'h10, 5'd1, F_BR, 1'b1, 32'h0, 1'b0);
        IF_pc = 32'h10;
        #1;
        total++; if (pred_ghr !== 5'b00011) begin bad++; $display("FAIL gshare_ghr1 got=%b exp=00011", pred_ghr); end
        total++; if (predicted_pc !== 32'h14) begin bad++; $display("FAIL gshare_idx7 got=%h exp=%h", predicted_pc, 32'h14); end
        repeat (2) train(32'h10, 5'd3, F_BR, 1'b1, 32'h0, 1'b0);
        #1;
        total++; if (pred_ghr !== 5'b01111) begin bad++; $display("FAIL gshare_ghr2 got=%b exp=01111", pred_ghr); end
        total++; if (predicted_pc !== 32'h14) begin bad++; $display("FAIL gshare_idx11 got=%h exp=%h", predicted_pc, 32'h14); end
        repeat (2) train(32'h10, 5'd15, F_BR, 1'b1, 32'h0, 1'b0);
        #1;
        total++; if (predicted_pc !== exp_pc(32'h10)) begin bad++; $display("FAIL gshare_model got=%h exp=%h", predicted_pc, exp_pc(32'h10)); end
        total++; if (pred_ghr !== m_ghr) begin bad++; $display("FAIL gshare_ghr3 got=%b exp=%b", pred_ghr, m_ghr); end
    endtask

    // 0x30 is always trained with upd_ghr=31; 0x34 taken updates restore GHR to 11111 so lookups see that counter
    task automatic test_saturation();
        logic [31:0] exp [4] = '{32'h200, 32'h200, 32'h34, 32'h34};
        do_reset();
        IF_pc = 32'h30;
        repeat (5) train(32'h30, 5'd31, F_BR, 1'b1, 32'h200, 1'b0);
        #1;
        total++; if (predicted_pc !== exp[0]) begin bad++; $display("FAIL sat_top got=%h exp=%h", predicted_pc, exp[0]); end
        train(32'h30, 5'd31, F_BR, 1'b0, 32'h200, 1'b0);
        repeat (5) train(32'h34, 5'd0, F_BR, 1'b1, 32'h300, 1'b0);
        #1;
        total++; if (predicted_pc !== exp[1]) begin bad++; $display("FAIL sat_top_dec got=%h exp=%h", predicted_pc, exp[1]); end
        repeat (2) train(32'h30, 5'd31, F_BR, 1'b0, 32'h200, 1'b0);
        repeat (5) train(32'h34, 5'd0, F_BR, 1'b1, 32'h300, 1'b0);
        #1;
        total++; if (predicted_pc !== exp[2]) begin bad++; $display("FAIL sat_bottom got=%h exp=%h", predicted_pc, exp[2]); end
        train(32'h30, 5'd31, F_BR, 1'b1, 32'h200, 1'b0);
        #1;
        total++; if (predicted_pc !== exp[3]) begin bad++; $display("FAIL sat_bottom_inc got=%h exp=%h", predicted_pc, exp[3]); end
        train(32'h30, 5'd31, F_BR, 1'b1, 32'h200, 1'b0);
        #1;
        total++; if (predicted_pc !== 32'h200) begin bad++; $display("FAIL sat_recover got=%h exp=%h", predicted_pc, 32'h200); end
    endtask

    task automatic test_ras();
        logic [31:0] exp [6] = '{32'h508, 32'h408, 32'h308, 32'h208, 32'h34, 32'h34};
        do_reset();
        train(32'h80, 5'd0, F_RET, 1'b0, 32'h34, 1'b0);
        for (int k = 1; k <= 5; k++) train(32'h100 * k + 32'h4, 5'd0, F_CALL, 1'b0, 32'h900, 1'b0);
        IF_pc = 32'h80;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (predicted_pc !== exp[i]) begin bad++; $display("FAIL ras_pop%0d got=%h exp=%h", i, predicted_pc, exp[i]); end
            train(32'h80, 5'd0, F_RET, 1'b0, 32'h34, 1'b0);
        end
        train(32'h604, 5'd0, F_CALL, 1'b0, 32'h900, 1'b0);
        train(32'h704, 5'd0, F_CALL | F_RET, 1'b0, 32'h900, 1'b0);
        #1;
        total++; if (predicted_pc !== 32'h708) begin bad++; $display("FAIL ras_callret got=%h exp=%h", predicted_pc, 32'h708); end
        train(32'h80, 5'd0, F_RET, 1'b0, 32'h34, 1'b0);
        #1;
        total++; if (predicted_pc !== 32'h34) begin bad++; $display("FAIL ras_callret_count got=%h exp=%h", predicted_pc, 32'h34); end
    endtask

    task automatic test_stall();
        do_reset();
        IF_pc = 32'h60;
        train(32'h60, 5'd1, F_BR | F_CALL, 1'b1, 32'h200, 1'b1);
        #1;
        total++; if (predicted_pc !== 32'h64) begin bad++; $display("FAIL stall_btb got=%h exp=%h", predicted_pc, 32'h64); end
        total++; if (pred_ghr !== 5'd0) begin bad++; $display("FAIL stall_ghr got=%b exp=00000", pred_ghr); end
        train(32'h60, 5'd1, F_BR, 1'b1, 32'h200, 1'b0);
        #1;
        total++; if (predicted_pc !== 32'h200) begin bad++; $display("FAIL unstall_pred got=%h exp=%h", predicted_pc, 32'h200); end
        total++; if (pred_ghr !== 5'd1) begin bad++; $display("FAIL unstall_ghr got=%b exp=00001", pred_ghr); end
    endtask

    task automatic test_async_reset();
        train(32'h20, 5'd0, F_JMP, 1'b0, 32'h100, 1'b0);
        train(32'h10, 5'd0, F_BR, 1'b1, 32'h0, 1'b0);
        IF_pc = 32'h20;
        #1;
        total++; if (predicted_pc !== 32'h100) begin bad++; $display("FAIL areset_pre got=%h exp=%h", predicted_pc, 32'h100); end
        #1;
        reset = 1'b1;
        #1;
        total++; if (predicted_pc !== 32'h24) begin bad++; $display("FAIL areset_pc got=%h exp=%h", predicted_pc, 32'h24); end
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL areset_taken got=%b exp=0", pred_taken); end
        total++; if (pred_ghr !== 5'd0) begin bad++; $display("FAIL areset_ghr got=%b exp=00000", pred_ghr); end
        reset = 1'b0;
        clear_model();
    endtask

    task automatic test_random();
        logic [31:0] e;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            IF_pc         = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 2);
            upd_pc        = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 2);
            upd_valid     = $urandom_range(0, 3) != 0;
            is_stall      = $urandom_range(0, 4) == 0;
            upd_ghr       = $urandom_range(0, 1) ? m_ghr : 5'($urandom);
            upd_is_branch = $urandom_range(0, 1) == 1;
            upd_is_jump   = $urandom_range(0, 5) == 0;
            upd_is_call   = $urandom_range(0, 4) == 0;
            upd_is_ret    = $urandom_range(0, 4) == 0;
            upd_taken     = 1'($urandom);
            upd_target    = $urandom & 32'hFFFF_FFFC;
            #1;
            e = exp_pc(IF_pc);
            total++; if (predicted_pc !== e) begin bad++; $display("FAIL rand_pc n=%0d got=%h exp=%h", n, predicted_pc, e); end
            total++; if (pred_taken !== (e != IF_pc + 4)) begin bad++; $display("FAIL rand_taken n=%0d got=%b exp=%b", n, pred_taken, e != IF_pc + 4); end
            total++; if (pred_ghr !== m_ghr) begin bad++; $display("FAIL rand_ghr n=%0d got=%b exp=%b", n, pred_ghr, m_ghr); end
            @(posedge clk);
            #1;
            if (upd_valid && !is_stall) model_apply();
        end
        upd_valid = 1'b0;
        is_stall  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; is_stall = 1'b0; upd_valid = 1'b0; IF_pc = '0; upd_pc = '0; upd_ghr = '0;
        upd_is_branch = 1'b0; upd_is_jump = 1'b0; upd_is_call = 1'b0; upd_is_ret = 1'b0;
        upd_taken = 1'b0; upd_target = '0;
        clear_model();
        @(posedge clk);
        #1;
        reset = 1'b0;
        test_reset();
        test_jump();
        test_gshare();
        test_saturation();
        test_ras();
        test_stall();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
